mux_scan_serializer: RTL and testbench
======================================

# mux_scan_serializer

Sequencing stage that drives an 8:1 selector mux from upstream: it latches an 8-bit word onto the mux data inputs, steps the mux select through all eight positions, samples the mux output at each position, and streams the bits downstream over a valid/ready handshake. It also rebuilds the sampled bits into a readback word, so the bench and system can check the mux path end-to-end. It sits between the word source and the serial consumer, wrapped around the combinational mux.

## Interface
- MSB_FIRST, 0, select order: 0 steps sel 0→7; 1 steps sel 7→0

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new scan; sampled only in IDLE
- load_data  in  8  word captured on an accepted start
- abort  in  1  synchronous cancel of an active scan
- mux_in  out  8  registered word driven onto the mux data inputs
- mux_sel  out  3  registered select driven onto the mux
- mux_out  in  1  mux output, combinational from mux_in/mux_sel
- ser_data  out  1  registered serial bit
- ser_valid  out  1  ser_data valid
- ser_ready  in  1  downstream accepts ser_data
- rx_word  out  8  readback: rx_word[k] = bit sampled at sel k
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse after the eighth bit is accepted

## Operation
- The FSM has four states: IDLE, SAMPLE, SEND, DONE.
- IDLE:
  - If start=1: mux_in←load_data, mux_sel←first (0, or 7 if MSB_FIRST), rx_word←0, bit counter←0, go to SAMPLE.
  - Otherwise hold. Every output keeps its value, including mux_in and rx_word.
- SAMPLE (one cycle):
  - ser_data←mux_out, rx_word[mux_sel]←mux_out, ser_valid←1, go to SEND.
- SEND:
  - Hold ser_data and ser_valid stable until ser_ready=1.
  - On a handshake with counter=7: ser_valid←0, go to DONE.
  - On a handshake otherwise: counter+1, mux_sel steps (+1, or −1 if MSB_FIRST), ser_valid←0, go to SAMPLE.
- DONE (one cycle):
  - done=1, then go to IDLE.
  - mux_sel returns to the first value.
- Select arithmetic is 3-bit. The counter, not mux_sel, ends the scan, so there is no wrap past the last position.
- start is ignored while busy=1; it is not queued.
- abort=1 in SAMPLE, SEND or DONE:
  - Next state is IDLE; ser_valid←0, done←0, mux_sel←first.
  - mux_in and rx_word hold their partial contents.
  - abort has priority over a simultaneous handshake. The bit counts as consumed downstream, but done does not pulse.
  - abort in IDLE has no effect.
  - If abort and start arrive together in IDLE, start is accepted.

## Timing
- Reset (asynchronous, rst_n=0):
  - State→IDLE.
  - mux_in=0, mux_sel=0 (7 if MSB_FIRST), ser_data=0, ser_valid=0, rx_word=0, busy=0, done=0.
- Start latency:
  - Start accepted at edge 0; mux_in and mux_sel update at edge 0.
  - First ser_valid=1 after edge 1.
- Per-bit cost is 2 cycles minimum: one SAMPLE cycle plus at least one SEND cycle. Each ser_ready=0 cycle in SEND adds one cycle.
- With ser_ready tied high:
  - ser_valid is high after edges 1, 3, …, 15.
  - Handshakes occur at edges 2, 4, …, 16.
  - done is high after edge 16 for one cycle.
  - busy falls after edge 17; a new start is accepted at edge 17 at the earliest.
- ser_valid never deasserts without a handshake, except on abort or reset.
- ser_data is stable while ser_valid=1 and ser_ready=0.
- mux_out is sampled one full cycle after mux_sel changes.

## Test plan
- Reset mid-scan: assert rst_n=0 during SEND at bit 3 → all outputs take reset values immediately; the next start begins a fresh scan from sel 0.
- LSB-first pass with ser_ready=1, load_data=8'hA5:
  - ser_data sequence is 1,0,1,0,0,1,0,1.
  - mux_sel visits 0..7.
  - done pulses after edge 16; rx_word=8'hA5.
- MSB_FIRST=1, load_data=8'h3C:
  - ser_data sequence is 0,0,1,1,1,1,0,0 and mux_sel visits 7..0.
  - rx_word=8'h3C.
- Backpressure with load_data=8'hFF: hold ser_ready=0 for 5 cycles on bit 2 → ser_valid and ser_data stay stable, mux_sel holds at 2, and done is delayed by exactly 5 cycles (after edge 21).
- start pulsed during busy with a different word (8'h00) → ignored; the scan completes with rx_word=8'hFF.
- Abort together with ser_ready on the bit-4 handshake → IDLE next cycle, no done pulse, ser_valid=0, rx_word holds bits 0..4. A following start with load_data=8'h81 completes normally with rx_word=8'h81.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// Steps an external 8:1 mux through every select position, serializes the
// sampled bits over valid/ready and rebuilds them into a readback word.
module mux_scan_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] load_data,
  input  logic       abort,
  output logic [7:0] mux_in,
  output logic [2:0] mux_sel,
  input  logic       mux_out,
  output logic       ser_data,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic [7:0] rx_word,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    SEND,
    DONE
  } state_t;

  localparam logic [2:0] FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  // adding 7 in 3-bit arithmetic is a decrement
  localparam logic [2:0] STEP  = MSB_FIRST ? 3'd7 : 3'd1;

  state_t     state;
  logic [2:0] cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      mux_in    <= 8'd0;
      mux_sel   <= FIRST;
      ser_data  <= 1'b0;
      ser_valid <= 1'b0;
      rx_word   <= 8'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort wins over a same-cycle handshake; partial data is kept
      if (abort && state != IDLE) begin
        state     <= IDLE;
        ser_valid <= 1'b0;
        mux_sel   <= FIRST;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              mux_in  <= load_data;
              mux_sel <= FIRST;
              rx_word <= 8'd0;
              cnt     <= 3'd0;
              state   <= SAMPLE;
            end
          end
          SAMPLE: begin
            ser_data         <= mux_out;
            rx_word[mux_sel] <= mux_out;
            ser_valid        <= 1'b1;
            state            <= SEND;
          end
          SEND: begin
            if (ser_ready) begin
              ser_valid <= 1'b0;
              if (cnt == 3'd7) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                cnt     <= cnt + 3'd1;
                mux_sel <= mux_sel + STEP;
                state   <= SAMPLE;
              end
            end
          end
          DONE: begin
            mux_sel <= FIRST;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Scoreboard bench for mux_scan_serializer: one LSB-first and one MSB-first
// instance, each wrapped around a behavioural 8:1 mux.
module tb_mux_scan_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [7:0] load_data [2];
  logic [1:0] abort;
  logic [7:0] mux_in [2];
  logic [2:0] mux_sel [2];
  logic [1:0] mux_out;
  logic [1:0] ser_data;
  logic [1:0] ser_valid;
  logic [1:0] ser_ready;
  logic [7:0] rx_word [2];
  logic [1:0] busy;
  logic [1:0] done;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mux_scan_serializer #(.MSB_FIRST(g == 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .load_data (load_data[g]),
      .abort     (abort[g]),
      .mux_in    (mux_in[g]),
      .mux_sel   (mux_sel[g]),
      .mux_out   (mux_out[g]),
      .ser_data  (ser_data[g]),
      .ser_valid (ser_valid[g]),
      .ser_ready (ser_ready[g]),
      .rx_word   (rx_word[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
    assign mux_out[g] = mux_in[g][mux_sel[g]];
  end

  typedef struct packed {
    logic       b;
    logic [2:0] sel;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] rx_q  [$];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on every handshake and every done pulse
  logic [1:0] hold_v = 2'b00;
  logic [1:0] hold_d = 2'b00;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        hold_v[g] = 1'b0;
      end else begin
        if (hold_v[g]) begin
          chk("stall_valid", ser_valid[g], 1'b1);
          chk("stall_data", ser_data[g], hold_d[g]);
        end
        if (ser_valid[g] && ser_ready[g]) begin
          if (exp_q.size() == 0) begin
            chk("extra_bit", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ser_data", ser_data[g], e.b);
            chk("bit_sel", mux_sel[g], e.sel);
          end
        end
        hold_v[g] = ser_valid[g] && !ser_ready[g] && !abort[g];
        hold_d[g] = ser_data[g];
        if (done[g]) begin
          if (rx_q.size() == 0) chk("extra_done", 1, 0);
          else chk("rx_word", rx_word[g], rx_q.pop_front());
        end
      end
    end
  end

  // mode 0: ready high, 1: random ready, 2: backpressure on bit 2 plus a
  // start while busy, 3: abort on bit-4 handshake, 4: reset during bit 3
  task automatic run_scan(input int i, input logic [7:0] w, input int mode);
    int         cyc, nbits, hold, done_edge, nexp;
    logic       hs, ab, quit;
    logic [2:0] first, s;
    exp_t       e;
    first = (i == 1) ? 3'd7 : 3'd0;
    nexp  = (mode == 3) ? 5 : (mode == 4) ? 3 : 8;
    for (int k = 0; k < nexp; k++) begin
      s     = (i == 1) ? 3'(7 - k) : 3'(k);
      e.b   = w[s];
      e.sel = s;
      exp_q.push_back(e);
    end
    if (mode < 3) rx_q.push_back(w);
    start[i]     = 1'b1;
    load_data[i] = w;
    @(posedge clk); #1;
    start[i]     = 1'b0;
    load_data[i] = 8'($urandom);
    chk("start_mux_in", mux_in[i], w);
    chk("start_sel", mux_sel[i], first);
    chk("start_busy", busy[i], 1'b1);
    cyc = 0; nbits = 0; hold = 0; done_edge = -1; quit = 1'b0;
    while (done_edge < 0 && cyc < 200 && !quit) begin
      start[i]     = 1'b0;
      ser_ready[i] = 1'b1;
      abort[i]     = 1'b0;
      case (mode)
        1: ser_ready[i] = ($urandom_range(0, 3) != 0);
        2: begin
          if (ser_valid[i] && nbits == 2 && hold < 5) begin
            ser_ready[i] = 1'b0;
            hold++;
            chk("bp_sel", mux_sel[i], 3'd2);
          end
          if (cyc == 6) begin
            start[i]     = 1'b1;
            load_data[i] = 8'h00;
          end
        end
        3: if (ser_valid[i] && nbits == 4) abort[i] = 1'b1;
        4: if (ser_valid[i] && nbits == 3) begin
          ser_ready[i] = 1'b0;
          #2 rst_n = 1'b0;
          #1;
          chk("rst_mux_in", mux_in[i], 8'd0);
          chk("rst_sel", mux_sel[i], first);
          chk("rst_ser_data", ser_data[i], 1'b0);
          chk("rst_valid", ser_valid[i], 1'b0);
          chk("rst_rx_word", rx_word[i], 8'd0);
          chk("rst_busy", busy[i], 1'b0);
          chk("rst_done", done[i], 1'b0);
          chk("rst_sel_msb", mux_sel[1], 3'd7);
          @(posedge clk); #1;
          rst_n = 1'b1;
          quit  = 1'b1;
        end
        default: ;
      endcase
      if (!quit) begin
        hs = ser_valid[i] && ser_ready[i];
        ab = abort[i];
        @(posedge clk); #1;
        cyc++;
        if (hs) nbits++;
        if (ab) begin
          abort[i] = 1'b0;
          chk("abort_busy", busy[i], 1'b0);
          chk("abort_valid", ser_valid[i], 1'b0);
          chk("abort_done", done[i], 1'b0);
          chk("abort_sel", mux_sel[i], first);
          chk("abort_rx", rx_word[i], w & 8'h1F);
          chk("abort_mux_in", mux_in[i], w);
          repeat (3) @(posedge clk);
          #1;
          quit = 1'b1;
        end else if (done[i]) begin
          done_edge = cyc;
        end
      end
    end
    ser_ready[i] = 1'b1;
    start[i]     = 1'b0;
    if (mode < 3) begin
      if (done_edge < 0) chk("timeout", 1, 0);
      if (mode == 0) chk("done_edge", done_edge, 16);
      if (mode == 2) chk("bp_done_edge", done_edge, 21);
      chk("busy_in_done", busy[i], 1'b1);
      @(posedge clk); #1;
      chk("idle_busy", busy[i], 1'b0);
      chk("idle_done", done[i], 1'b0);
      chk("idle_sel", mux_sel[i], first);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 2'b00;
    abort     = 2'b00;
    ser_ready = 2'b11;
    load_data[0] = 8'd0;
    load_data[1] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sel_lsb", mux_sel[0], 3'd0);
    chk("reset_sel_msb", mux_sel[1], 3'd7);
    chk("reset_valid", ser_valid, 2'b00);
    chk("reset_busy", busy, 2'b00);
    chk("reset_rx", rx_word[0], 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_scan(0, 8'hA5, 0);
    run_scan(1, 8'h3C, 0);
    run_scan(0, 8'hFF, 2);
    run_scan(0, 8'($urandom), 3);
    run_scan(0, 8'h81, 0);
    run_scan(0, 8'($urandom), 4);
    run_scan(0, 8'($urandom), 0);
    for (int n = 0; n < 8; n++) run_scan(n % 2, 8'($urandom), 1);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("rx_queue_empty", rx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
